extmem_arbiter: RTL and testbench

EXTMEM_ARBITER -- requirements
Module: extmem_arbiter

---
 rtl/extmem_arbiter_if.sv | 17 +
 rtl/extmem_arbiter.sv | 123 ++++++++++++
 tb/tb_extmem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/extmem_arbiter_if.sv
// Requester-side bundle of the external memory arbiter: one instance per
// requesting port (PDP-8 memory cycle on A, ARM AXI mapper on B).
interface extmem_arbiter_if;
  logic        req;
  logic        wena;
  logic [14:0] addr;
  logic [11:0] wdat;
  logic        done;
  logic [11:0] rdat;

  // The requester drives the access and watches for completion.
  modport master (output req, output wena, output addr, output wdat,
                  input  done, input  rdat);
  // The arbiter samples the access and returns completion and read data.
  modport slave  (input  req, input  wena, input  addr, input  wdat,
                  output done, output rdat);
endinterface

// File: rtl/extmem_arbiter.sv
// Two-port arbiter in front of a single block RAM. One access at a time:
// IDLE grants a port and latches its request, ACCESS holds the RAM enabled
// for LATENCY cycles, DONE pulses the winner's done for one cycle. Port A
// normally wins, but after STARVE consecutive A grants with B waiting, B wins.
module extmem_arbiter #(
  parameter int LATENCY = 3,   // block-RAM cycles per access, 1..7
  parameter int STARVE  = 4    // max consecutive A grants while B waits, 1..15
) (
  input  logic                CLOCK,
  input  logic                RESET_N,
  extmem_arbiter_if.slave     port_a,
  extmem_arbiter_if.slave     port_b,
  output logic [14:0]         xbraddr,
  output logic [11:0]         xbrwdat,
  output logic                xbrenab,
  output logic                xbrwena,
  input  logic [11:0]         xbrrdat,
  output logic                busy,
  output logic                owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_CYCLE = 3'(LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cyc_cnt;
  logic [3:0]  starve_cnt;
  logic [14:0] lat_addr;
  logic [11:0] lat_wdat;
  logic        lat_wena;
  logic [11:0] a_rdat_q;
  logic [11:0] b_rdat_q;
  logic        grant;
  logic        grant_b;
  logic        access_end;

  // Next-state and grant decision.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_b    = 1'b0;
    access_end = 1'b0;
    case (state)
      IDLE: begin
        if (port_a.req || port_b.req) begin
          grant     = 1'b1;
          // B wins when alone, or when A has starved it for STARVE grants.
          grant_b   = port_b.req && (!port_a.req || (starve_cnt == STARVE_MAX));
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        access_end = (cyc_cnt == LAST_CYCLE);
        if (access_end) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any access in flight.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // Grant latching, cycle counting, starvation tracking and read-data capture.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      owner      <= 1'b0;
      lat_addr   <= '0;
      lat_wdat   <= '0;
      lat_wena   <= 1'b0;
      cyc_cnt    <= '0;
      starve_cnt <= '0;
      a_rdat_q   <= '0;
      b_rdat_q   <= '0;
    end else begin
      if (grant) begin
        owner    <= grant_b;
        lat_addr <= grant_b ? port_b.addr : port_a.addr;
        lat_wdat <= grant_b ? port_b.wdat : port_a.wdat;
        lat_wena <= grant_b ? port_b.wena : port_a.wena;
        cyc_cnt  <= '0;
        // Count only A grants that made B wait; saturate at the limit.
        if (grant_b || !port_b.req)      starve_cnt <= '0;
        else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 4'd1;
      end else if (state == ACCESS) begin
        cyc_cnt <= cyc_cnt + 3'd1;
      end

      // Read data is taken on the edge that closes the last RAM cycle.
      if (access_end && !lat_wena) begin
        if (owner) b_rdat_q <= xbrrdat;
        else       a_rdat_q <= xbrrdat;
      end
    end
  end

  // RAM side sees only latched values, so requester changes after the grant
  // have no effect until the next grant.
  assign xbraddr     = lat_addr;
  assign xbrwdat     = lat_wdat;
  assign xbrenab     = (state == ACCESS);
  assign xbrwena     = xbrenab && lat_wena;
  assign busy        = (state != IDLE);
  assign port_a.done = (state == DONE) && !owner;
  assign port_b.done = (state == DONE) &&  owner;
  assign port_a.rdat = a_rdat_q;
  assign port_b.rdat = b_rdat_q;

endmodule

// File: tb/tb_extmem_arbiter.sv
// Self-checking bench for extmem_arbiter. The main instance (LATENCY=3) runs
// directed and random transactions against a transaction-level model
// (winner choice, starvation count, memory contents, per-port read data).
// Two extra instances (LATENCY=1 and 7) are exercised by random traffic and
// watched for enable width, done placement and the DONE gap.
module tb_extmem_arbiter;

  localparam int LAT = 3;
  localparam int STV = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n_lat;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- main instance ----------------
  extmem_arbiter_if a_if ();
  extmem_arbiter_if b_if ();
  logic [14:0] xbraddr;
  logic [11:0] xbrwdat;
  logic        xbrenab;
  logic        xbrwena;
  logic [11:0] xbrrdat;
  logic        busy;
  logic        owner;

  extmem_arbiter #(.LATENCY(LAT), .STARVE(STV)) u_dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .port_a  (a_if),
    .port_b  (b_if),
    .xbraddr (xbraddr),
    .xbrwdat (xbrwdat),
    .xbrenab (xbrenab),
    .xbrwena (xbrwena),
    .xbrrdat (xbrrdat),
    .busy    (busy),
    .owner   (owner)
  );

  // Block-RAM stand-in: asynchronous read, write on enabled edges.
  logic [11:0] bram [0:32767];
  logic        preload_en;
  logic [14:0] preload_addr;
  logic [11:0] preload_dat;
  always @(posedge clk) begin
    if (preload_en)                bram[preload_addr] <= preload_dat;
    else if (xbrenab && xbrwena)   bram[xbraddr]      <= xbrwdat;
  end
  assign xbrrdat = bram[xbraddr];

  // Reference model state.
  logic [11:0] ref_mem [logic [14:0]];
  logic [11:0] exp_a_rdat;
  logic [11:0] exp_b_rdat;
  int          starve_m;

  function automatic logic [11:0] ref_rd(input logic [14:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 12'h000;
  endfunction

  // One transaction, entered and left at a negedge inside an IDLE cycle.
  task automatic do_txn(input bit ra, input bit rb,
                        input bit awe, input logic [14:0] aad, input logic [11:0] awd,
                        input bit bwe, input logic [14:0] bad, input logic [11:0] bwd);
    bit          win_b;
    bit          we;
    logic [14:0] ad;
    logic [11:0] wd;
    int          width;
    check("idle_busy", busy, 0);
    check("idle_enab", xbrenab, 0);
    a_if.req = ra; a_if.wena = awe; a_if.addr = aad; a_if.wdat = awd;
    b_if.req = rb; b_if.wena = bwe; b_if.addr = bad; b_if.wdat = bwd;
    if (!ra && !rb) begin
      @(negedge clk);
      check("noreq_busy", busy, 0);
      check("noreq_enab", xbrenab, 0);
      return;
    end
    // Winner from the priority rule, then starvation bookkeeping.
    win_b = rb && (!ra || starve_m == STV);
    if (win_b || !rb)     starve_m = 0;
    else if (starve_m < STV) starve_m = starve_m + 1;
    we = win_b ? bwe : awe;
    ad = win_b ? bad : aad;
    wd = win_b ? bwd : awd;

    @(negedge clk);
    check("grant_busy",  busy, 1);
    check("grant_owner", owner, win_b);
    check("grant_addr",  xbraddr, ad);
    check("grant_wdat",  xbrwdat, wd);
    check("grant_wena",  xbrwena, we);
    // The winner scribbles on its inputs; the RAM side must not follow.
    if (win_b) begin
      b_if.addr = 15'($urandom); b_if.wdat = 12'($urandom); b_if.wena = 1'($urandom);
    end else begin
      a_if.addr = 15'h0001;      a_if.wdat = 12'($urandom); a_if.wena = 1'($urandom);
    end
    width = 0;
    while (xbrenab && width < 20) begin
      width++;
      check("hold_addr", xbraddr, ad);
      check("hold_wena", xbrwena, we);
      check("acc_done",  a_if.done | b_if.done, 0);
      @(negedge clk);
    end
    check("enab_width", width, LAT);

    // DONE cycle.
    check("done_a",    a_if.done, !win_b);
    check("done_b",    b_if.done, win_b);
    check("done_busy", busy, 1);
    check("done_enab", xbrenab, 0);
    if (we) ref_mem[ad] = wd;
    else if (win_b) exp_b_rdat = ref_rd(ad);
    else            exp_a_rdat = ref_rd(ad);
    check("a_rdat", a_if.rdat, exp_a_rdat);
    check("b_rdat", b_if.rdat, exp_b_rdat);
    if (win_b) b_if.req = 1'b0;
    else       a_if.req = 1'b0;

    @(negedge clk);
    check("post_busy", busy, 0);
    check("post_enab", xbrenab, 0);
    check("post_done", a_if.done | b_if.done, 0);
  endtask

  // ---------------- LATENCY=1 / LATENCY=7 instances ----------------
  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int LG = (g == 0) ? 1 : 7;
    extmem_arbiter_if la ();
    extmem_arbiter_if lb ();
    logic [14:0] gaddr;
    logic [11:0] gwdat;
    logic        genab;
    logic        gwena;
    logic        gbusy;
    logic        gown;
    bit          fin;
    int          run;
    bit          prev_done;

    extmem_arbiter #(.LATENCY(LG), .STARVE(STV)) u_dut (
      .CLOCK   (clk),
      .RESET_N (rst_n_lat),
      .port_a  (la),
      .port_b  (lb),
      .xbraddr (gaddr),
      .xbrwdat (gwdat),
      .xbrenab (genab),
      .xbrwena (gwena),
      .xbrrdat (12'o0000),
      .busy    (gbusy),
      .owner   (gown)
    );

    // Enable run length, done right after each run, no enable after a done.
    always @(negedge clk) begin
      if (rst_n_lat) begin
        if (prev_done) check("lat_gap", genab, 0);
        if (genab) begin
          run <= run + 1;
        end else if (run > 0) begin
          check("lat_width", run, LG);
          check("lat_done",  la.done | lb.done, 1);
          run <= 0;
        end
        if (la.done | lb.done) check("lat_excl", la.done & lb.done, 0);
        prev_done <= la.done | lb.done;
      end
    end

    // Back-to-back random traffic: new requests are raised in the DONE cycle.
    initial begin
      bit got;
      run = 0; prev_done = 1'b0; fin = 1'b0;
      la.req = 0; la.wena = 0; la.addr = '0; la.wdat = '0;
      lb.req = 0; lb.wena = 0; lb.addr = '0; lb.wdat = '0;
      wait (rst_n_lat === 1'b1);
      @(negedge clk);
      for (int t = 0; t < 25; t++) begin
        la.req = 1'($urandom); lb.req = 1'($urandom);
        if (!la.req && !lb.req) lb.req = 1'b1;
        la.wena = 1'($urandom); la.addr = 15'($urandom); la.wdat = 12'($urandom);
        lb.wena = 1'($urandom); lb.addr = 15'($urandom); lb.wdat = 12'($urandom);
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
          @(negedge clk);
          got = la.done | lb.done;
        end
        check("lat_timeout", got, 1);
      end
      la.req = 1'b0; lb.req = 1'b0;
      repeat (3) @(negedge clk);
      fin = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [14:0] ad;
    int          seen;
    rst_n = 1'b0; rst_n_lat = 1'b0;
    preload_en = 1'b0; preload_addr = '0; preload_dat = '0;
    a_if.req = 0; a_if.wena = 0; a_if.addr = '0; a_if.wdat = '0;
    b_if.req = 0; b_if.wena = 0; b_if.addr = '0; b_if.wdat = '0;
    exp_a_rdat = '0; exp_b_rdat = '0; starve_m = 0;
    repeat (2) @(negedge clk);

    check("rst_busy",  busy, 0);
    check("rst_enab",  xbrenab, 0);
    check("rst_wena",  xbrwena, 0);
    check("rst_owner", owner, 0);
    check("rst_done",  {a_if.done, b_if.done}, 0);
    check("rst_rdat",  {a_if.rdat, b_if.rdat}, 0);
    check("rst_addr",  xbraddr, 0);
    check("rst_wdat",  xbrwdat, 0);

    // Seed a small address pool plus the B read location.
    for (int i = 0; i < 9; i++) begin
      preload_en   = 1'b1;
      preload_addr = (i == 8) ? 15'h0100 : 15'(i);
      preload_dat  = (i == 8) ? 12'o0017 : 12'($urandom);
      ref_mem[preload_addr] = preload_dat;
      @(negedge clk);
    end
    preload_en = 1'b0;
    rst_n = 1'b1; rst_n_lat = 1'b1;
    @(negedge clk);

    // Write then read on A.
    do_txn(1, 0, 1, 15'h1234, 12'o7654, 0, '0, '0);
    do_txn(1, 0, 0, 15'h1234, 12'o0000, 0, '0, '0);
    check("a_read_back", a_if.rdat, 12'o7654);

    // Lone B read; A's read data must not move.
    do_txn(0, 1, 0, '0, '0, 0, 15'h0100, '0);
    check("b_read_0017", b_if.rdat, 12'o0017);
    check("a_rdat_kept", a_if.rdat, 12'o7654);

    // Both held: four A grants, then B, then the count restarts.
    for (int i = 0; i < 10; i++)
      do_txn(1, 1, 1'($urandom), 15'($urandom_range(0, 7)), 12'($urandom),
             1'($urandom), 15'($urandom_range(0, 7)), 12'($urandom));

    // Random mix, including idle cycles with no request.
    for (int i = 0; i < 40; i++)
      do_txn(1'($urandom), 1'($urandom),
             1'($urandom), 15'($urandom_range(0, 7)), 12'($urandom),
             1'($urandom), 15'($urandom_range(0, 7)), 12'($urandom));

    // Reset in the second ACCESS cycle of an A read.
    ad = 15'h0002;
    a_if.req = 1'b1; a_if.wena = 1'b0; a_if.addr = ad; b_if.req = 1'b0;
    @(negedge clk);
    check("abort_grant", xbrenab, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_enab",  xbrenab, 0);
    check("abort_wena",  xbrwena, 0);
    check("abort_busy",  busy, 0);
    check("abort_owner", owner, 0);
    check("abort_done",  {a_if.done, b_if.done}, 0);
    check("abort_rdat",  {a_if.rdat, b_if.rdat}, 0);
    check("abort_addr",  xbraddr, 0);
    exp_a_rdat = '0; exp_b_rdat = '0; starve_m = 0;
    a_if.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      if (a_if.done || b_if.done || busy) seen++;
    end
    check("abort_quiet", seen, 0);
    do_txn(1, 0, 0, ad, '0, 0, '0, '0);
    do_txn(0, 1, 0, '0, '0, 0, 15'h0100, '0);

    // Let the LATENCY=1/7 traffic finish.
    for (int c = 0; c < 5000 && !(g_lat[0].fin && g_lat[1].fin); c++) @(negedge clk);
    check("lat_runs_fin", {g_lat[0].fin, g_lat[1].fin}, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
